// File: rtl/axi_chacha.sv
`default_nettype none
// ============================================================================
// Module      : axi_chacha
// Description : AXI4-Lite slave around an iterative ChaCha20 engine. Software
//               loads key, nonce and plaintext, sets RUN, and reads back the
//               ciphertext once DATA_VALID is set.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_chacha #(
    parameter int NUMBER_OF_BLOCKS   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int          NWORDS    = 16 * NUMBER_OF_BLOCKS;
    localparam int          BW        = (NUMBER_OF_BLOCKS > 1) ? $clog2(NUMBER_OF_BLOCKS) : 1;
    localparam logic [31:0] VERSION   = 32'h1000_0000;
    localparam logic [31:0] DATA_SIZE = 32'(NUMBER_OF_BLOCKS * 64);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Register file
    logic [31:0] r_key     [8];
    logic [31:0] r_iv      [3];
    logic [31:0] r_data_in [NWORDS];
    logic [31:0] r_data_out[NWORDS];
    logic        r_run;
    logic        r_data_valid;

    // Engine state
    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_st   [16];
    logic [31:0] r_init [16];
    logic [31:0] w_init [16];
    logic [31:0] w_rnd  [16];
    logic [31:0] w_ks   [16];
    logic [4:0]  r_round;
    logic [BW-1:0] r_blk;
    logic        w_last;
    logic        w_load_en;
    logic        w_round_en;
    logic        w_final_en;

    // Bus side
    logic [C_S_AXI_ADDR_WIDTH-1:0] r_raddr;
    logic [31:0] w_rd_data;
    logic        w_wr_fire;
    logic        w_wr_mapped;
    logic [1:0]  w_wr_region;
    logic [13:0] w_wr_word;
    logic        w_ctrl_wr;
    logic        w_abort;
    logic        w_run_ok;
    logic        w_rd_mapped;
    logic [1:0]  w_rd_region;
    logic [13:0] w_rd_word;
    logic        w_unused_bits;

    // One ChaCha quarter-round; rotations written as concatenations.
    function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;
    assign w_unused_bits = ^{s_axi_awaddr[1:0], r_raddr[1:0]};

    // Write address decode; accept only when both channels are present.
    assign w_wr_fire   = s_axi_awvalid & s_axi_wvalid & ~s_axi_awready;
    assign w_wr_mapped = (s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:18] == '0);
    assign w_wr_region = s_axi_awaddr[17:16];
    assign w_wr_word   = s_axi_awaddr[15:2];
    assign w_ctrl_wr   = w_wr_fire & w_wr_mapped & (w_wr_region == 2'd0) & (w_wr_word == 14'd1);
    assign w_abort     = w_ctrl_wr & ~s_axi_wdata[0];
    assign w_run_ok    = r_run & ~w_abort;

    // Write handshake: one-cycle awready/wready pulse, bvalid until bready.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else begin
            s_axi_awready <= w_wr_fire;
            s_axi_wready  <= w_wr_fire;
            if (w_wr_fire)
                s_axi_bvalid <= 1'b1;
            else if (s_axi_bready)
                s_axi_bvalid <= 1'b0;
        end
    end

    // Software-writable registers; configuration is frozen while RUN is set.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_run <= 1'b0;
            for (int k = 0; k < 8; k++) r_key[k] <= '0;
            for (int k = 0; k < 3; k++) r_iv[k] <= '0;
            for (int i = 0; i < NWORDS; i++) r_data_in[i] <= '0;
        end else if (w_wr_fire && w_wr_mapped) begin
            if (w_wr_region == 2'd0) begin
                if (w_wr_word == 14'd1)
                    r_run <= s_axi_wdata[0];
                for (int k = 0; k < 8; k++)
                    if (!r_run && w_wr_word == 14'(k + 2)) r_key[k] <= s_axi_wdata;
                for (int k = 0; k < 3; k++)
                    if (!r_run && w_wr_word == 14'(k + 10)) r_iv[k] <= s_axi_wdata;
            end else if (w_wr_region == 2'd1) begin
                for (int i = 0; i < NWORDS; i++)
                    if (!r_run && w_wr_word == 14'(i)) r_data_in[i] <= s_axi_wdata;
            end
        end
    end

    // Read handshake: accept one address, then hold rvalid until rready.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            r_raddr       <= '0;
        end else begin
            if (s_axi_arvalid && !s_axi_arready && !s_axi_rvalid) begin
                s_axi_arready <= 1'b1;
                r_raddr       <= s_axi_araddr;
            end else begin
                s_axi_arready <= 1'b0;
            end
            if (s_axi_arready) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= w_rd_data;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    assign w_rd_mapped = (r_raddr[C_S_AXI_ADDR_WIDTH-1:18] == '0);
    assign w_rd_region = r_raddr[17:16];
    assign w_rd_word   = r_raddr[15:2];

    // Read data mux over the register map; unmapped addresses read zero.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_mapped) begin
            case (w_rd_region)
                2'd0: begin
                    if (w_rd_word == 14'd0) w_rd_data = VERSION;
                    if (w_rd_word == 14'd1) w_rd_data = {30'd0, r_data_valid, r_run};
                    for (int k = 0; k < 8; k++)
                        if (w_rd_word == 14'(k + 2)) w_rd_data = r_key[k];
                    for (int k = 0; k < 3; k++)
                        if (w_rd_word == 14'(k + 10)) w_rd_data = r_iv[k];
                    if (w_rd_word == 14'd13) w_rd_data = DATA_SIZE;
                end
                2'd1: begin
                    for (int i = 0; i < NWORDS; i++)
                        if (w_rd_word == 14'(i)) w_rd_data = r_data_in[i];
                end
                2'd2: begin
                    for (int i = 0; i < NWORDS; i++)
                        if (w_rd_word == 14'(i)) w_rd_data = r_data_out[i];
                end
                default: w_rd_data = '0;
            endcase
        end
    end

    // Initial ChaCha20 state for the current block.
    always_comb begin
        w_init[0]  = 32'h6170_7865;
        w_init[1]  = 32'h3320_646e;
        w_init[2]  = 32'h7962_2d32;
        w_init[3]  = 32'h6b20_6574;
        for (int k = 0; k < 8; k++) w_init[4 + k] = r_key[k];
        w_init[12] = 32'(r_blk);
        for (int k = 0; k < 3; k++) w_init[13 + k] = r_iv[k];
    end

    // One double-round half: column round on even counts, diagonal on odd.
    always_comb begin
        w_rnd = r_st;
        if (!r_round[0]) begin
            {w_rnd[0], w_rnd[4], w_rnd[8],  w_rnd[12]} = qr(r_st[0], r_st[4], r_st[8],  r_st[12]);
            {w_rnd[1], w_rnd[5], w_rnd[9],  w_rnd[13]} = qr(r_st[1], r_st[5], r_st[9],  r_st[13]);
            {w_rnd[2], w_rnd[6], w_rnd[10], w_rnd[14]} = qr(r_st[2], r_st[6], r_st[10], r_st[14]);
            {w_rnd[3], w_rnd[7], w_rnd[11], w_rnd[15]} = qr(r_st[3], r_st[7], r_st[11], r_st[15]);
        end else begin
            {w_rnd[0], w_rnd[5], w_rnd[10], w_rnd[15]} = qr(r_st[0], r_st[5], r_st[10], r_st[15]);
            {w_rnd[1], w_rnd[6], w_rnd[11], w_rnd[12]} = qr(r_st[1], r_st[6], r_st[11], r_st[12]);
            {w_rnd[2], w_rnd[7], w_rnd[8],  w_rnd[13]} = qr(r_st[2], r_st[7], r_st[8],  r_st[13]);
            {w_rnd[3], w_rnd[4], w_rnd[9],  w_rnd[14]} = qr(r_st[3], r_st[4], r_st[9],  r_st[14]);
        end
    end

    // Keystream is the working state plus the saved initial state.
    always_comb begin
        for (int j = 0; j < 16; j++) w_ks[j] = r_st[j] + r_init[j];
    end

    assign w_last = (r_blk == BW'(NUMBER_OF_BLOCKS - 1));

    // Engine state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Engine sequencing; clearing RUN forces the engine back to idle.
    always_comb begin
        w_state_next = r_state;
        w_load_en    = 1'b0;
        w_round_en   = 1'b0;
        w_final_en   = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_run_ok) w_state_next = ST_LOAD;
            ST_LOAD: begin
                w_load_en    = 1'b1;
                w_state_next = ST_ROUND;
            end
            ST_ROUND: begin
                w_round_en = 1'b1;
                if (r_round == 5'd19) w_state_next = ST_FINAL;
            end
            ST_FINAL: begin
                w_final_en   = 1'b1;
                w_state_next = w_last ? ST_DONE : ST_LOAD;
            end
            ST_DONE:  w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
        if (!w_run_ok) begin
            w_state_next = ST_IDLE;
            w_load_en    = 1'b0;
            w_round_en   = 1'b0;
            w_final_en   = 1'b0;
        end
    end

    // Working state, round counter and block counter.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int j = 0; j < 16; j++) begin
                r_st[j]   <= '0;
                r_init[j] <= '0;
            end
            r_round <= '0;
            r_blk   <= '0;
        end else begin
            if (w_load_en) begin
                r_st    <= w_init;
                r_init  <= w_init;
                r_round <= '0;
            end
            if (w_round_en) begin
                r_st    <= w_rnd;
                r_round <= r_round + 5'd1;
            end
            if (w_final_en && !w_last)
                r_blk <= r_blk + BW'(1);
            if (!w_run_ok)
                r_blk <= '0;
        end
    end

    // Ciphertext buffer: one block of plaintext XOR keystream per finalize.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NWORDS; i++) r_data_out[i] <= '0;
        end else if (w_final_en) begin
            for (int b = 0; b < NUMBER_OF_BLOCKS; b++)
                if (r_blk == BW'(b))
                    for (int j = 0; j < 16; j++)
                        r_data_out[16 * b + j] <= r_data_in[16 * b + j] ^ w_ks[j];
        end
    end

    // DATA_VALID: cleared on abort or fresh start, set after the last block.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_data_valid <= 1'b0;
        else if (w_ctrl_wr && (!s_axi_wdata[0] || !r_run))
            r_data_valid <= 1'b0;
        else if (w_final_en && w_last)
            r_data_valid <= 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_chacha.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_chacha
// Description : Directed self-checking bench for axi_chacha.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_chacha;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_key[8];
    logic [31:0] m_iv[3];
    logic [31:0] m_pt[16];
    logic [31:0] m_exp[16];
    logic [31:0] mx[16];
    logic [31:0] rfc_ks[16];
    logic [31:0] rd;
    logic [1:0]  br;

    axi_chacha #(
        .NUMBER_OF_BLOCKS  (1),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        do begin
            @(posedge aclk); #1;
            n++;
        end while (!s_axi_awready && n < 20);
        if (!s_axi_awready) begin
            total++; bad++;
            $display("FAIL wr_timeout: addr=%08h no awready", a);
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check_eq("wr_wready", 32'(s_axi_wready), 32'd1);
        check_eq("wr_bvalid", 32'(s_axi_bvalid), 32'd1);
        resp = s_axi_bresp;
        s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin
            @(posedge aclk); #1;
            n++;
        end while (!s_axi_arready && n < 20);
        if (!s_axi_arready) begin
            total++; bad++;
            $display("FAIL rd_timeout: addr=%08h no arready", a);
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        n = 0;
        do begin
            @(posedge aclk); #1;
            n++;
        end while (!s_axi_rvalid && n < 20);
        if (!s_axi_rvalid) begin
            total++; bad++;
            $display("FAIL rd_timeout: addr=%08h no rvalid", a);
        end
        d = s_axi_rdata;
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    task automatic mqr(input int a, input int b, input int c, input int d);
        mx[a] = mx[a] + mx[b]; mx[d] = rotl(mx[d] ^ mx[a], 16);
        mx[c] = mx[c] + mx[d]; mx[b] = rotl(mx[b] ^ mx[c], 12);
        mx[a] = mx[a] + mx[b]; mx[d] = rotl(mx[d] ^ mx[a], 8);
        mx[c] = mx[c] + mx[d]; mx[b] = rotl(mx[b] ^ mx[c], 7);
    endtask

    // Reference ChaCha20 block XORed with m_pt into m_exp.
    task automatic model_block(input logic [31:0] ctr);
        logic [31:0] s[16];
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = m_key[i];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13 + i] = m_iv[i];
        for (int i = 0; i < 16; i++) mx[i] = s[i];
        for (int r = 0; r < 10; r++) begin
            mqr(0, 4, 8, 12); mqr(1, 5, 9, 13); mqr(2, 6, 10, 14); mqr(3, 7, 11, 15);
            mqr(0, 5, 10, 15); mqr(1, 6, 11, 12); mqr(2, 7, 8, 13); mqr(3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) m_exp[i] = (mx[i] + s[i]) ^ m_pt[i];
    endtask

    initial begin
        rfc_ks = '{32'hade0b876, 32'h903df1a0, 32'he56a5d40, 32'h28bd8653,
                   32'hb819d2bd, 32'h1aed8da0, 32'hccef36a8, 32'hc70d778b,
                   32'h7c5941da, 32'h8d485751, 32'h3fe02477, 32'h374ad8b8,
                   32'hf4b8436a, 32'h1ca11815, 32'h69b687c3, 32'h8665eeb2};
        areset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_eq("rst_ready", {28'd0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid}, 32'd0);
        check_eq("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check_eq("rst_rdata", s_axi_rdata, 32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;

        // Reset-state register reads
        axi_read(32'h00, rd);      check_eq("version", rd, 32'h1000_0000);
        axi_read(32'h04, rd);      check_eq("ctrl_rst", rd, 32'h0);
        axi_read(32'h34, rd);      check_eq("data_size", rd, 32'd64);
        axi_read(32'h08, rd);      check_eq("key0_rst", rd, 32'h0);
        axi_read(32'h20000, rd);   check_eq("dout0_rst", rd, 32'h0);
        axi_read(32'h38, rd);      check_eq("unmapped", rd, 32'h0);

        // Read-only register write is ignored, response OKAY
        axi_write(32'h00, 32'hdeadbeef, br);
        check_eq("bresp", 32'(br), 32'd0);
        axi_read(32'h00, rd);      check_eq("version_ro", rd, 32'h1000_0000);

        // All-zero key/nonce/plaintext, counter 0: known keystream block
        axi_write(32'h04, 32'h1, br);
        axi_read(32'h04, rd);      check_eq("ctrl_run", rd, 32'h1);
        repeat (50) @(posedge aclk);
        #1;
        axi_read(32'h04, rd);      check_eq("ctrl_done", rd, 32'h3);
        for (int i = 0; i < 16; i++) begin
            axi_read(32'h20000 + 32'(4 * i), rd);
            check_eq($sformatf("zero_dout%0d", i), rd, rfc_ks[i]);
        end
        axi_write(32'h04, 32'h0, br);
        axi_read(32'h04, rd);      check_eq("ctrl_clr", rd, 32'h0);

        // Load key, nonce and plaintext, reading each back
        for (int i = 0; i < 8; i++) m_key[i] = 32'(7 - i);
        m_iv[0] = 32'h0a; m_iv[1] = 32'h09; m_iv[2] = 32'h08;
        for (int i = 0; i < 16; i++) m_pt[i] = 32'(8'h19 - i);
        for (int i = 0; i < 8; i++)  axi_write(32'h08 + 32'(4 * i), m_key[i], br);
        for (int i = 0; i < 3; i++)  axi_write(32'h28 + 32'(4 * i), m_iv[i], br);
        for (int i = 0; i < 16; i++) axi_write(32'h10000 + 32'(4 * i), m_pt[i], br);
        for (int i = 0; i < 8; i++) begin
            axi_read(32'h08 + 32'(4 * i), rd);   check_eq($sformatf("key%0d", i), rd, m_key[i]);
        end
        for (int i = 0; i < 3; i++) begin
            axi_read(32'h28 + 32'(4 * i), rd);   check_eq($sformatf("iv%0d", i), rd, m_iv[i]);
        end
        for (int i = 0; i < 16; i++) begin
            axi_read(32'h10000 + 32'(4 * i), rd); check_eq($sformatf("din%0d", i), rd, m_pt[i]);
        end
        model_block(32'd0);

        // Encrypt; config writes during the run must be ignored
        axi_write(32'h04, 32'h1, br);
        axi_write(32'h08, 32'hffffffff, br);
        axi_write(32'h10000, 32'hffffffff, br);
        axi_read(32'h04, rd);      check_eq("ctrl_run2", rd, 32'h1);
        repeat (50) @(posedge aclk);
        #1;
        axi_read(32'h04, rd);      check_eq("ctrl_done2", rd, 32'h3);
        axi_read(32'h08, rd);      check_eq("key0_locked", rd, m_key[0]);
        for (int i = 0; i < 16; i++) begin
            axi_read(32'h20000 + 32'(4 * i), rd);
            check_eq($sformatf("dout%0d", i), rd, m_exp[i]);
        end
        axi_read(32'h10000, rd);   check_eq("din0_kept", rd, m_pt[0]);
        axi_read(32'h1003c, rd);   check_eq("din15_kept", rd, m_pt[15]);

        // Abort mid-run: DATA_VALID never sets, old ciphertext retained
        axi_write(32'h04, 32'h0, br);
        axi_write(32'h04, 32'h1, br);
        repeat (5) @(posedge aclk);
        #1;
        axi_write(32'h04, 32'h0, br);
        axi_read(32'h04, rd);      check_eq("ctrl_abort", rd, 32'h0);
        repeat (40) @(posedge aclk);
        #1;
        axi_read(32'h04, rd);      check_eq("ctrl_abort_late", rd, 32'h0);
        axi_read(32'h20000, rd);   check_eq("dout0_kept", rd, m_exp[0]);

        // Restart produces the same ciphertext
        axi_write(32'h04, 32'h1, br);
        repeat (50) @(posedge aclk);
        #1;
        axi_read(32'h04, rd);      check_eq("ctrl_done3", rd, 32'h3);
        for (int i = 0; i < 16; i++) begin
            axi_read(32'h20000 + 32'(4 * i), rd);
            check_eq($sformatf("rerun_dout%0d", i), rd, m_exp[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
